// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int WAIT_NIB_W = 4;

  // Replicated across DATA_W to form the value returned by an unmapped read.
  localparam logic UNMAPPED_BIT = 1'b1;

endpackage

// File: rtl/mem_bus_waitcnt.sv
// Loadable down-counter for region wait states; zero flag ends the device access.
module mem_bus_waitcnt
  import mem_bus_pkg::*;
#(
  parameter int W = WAIT_NIB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: region decode, per-region wait states, ready handshake.
// Optional macro MEM_BUS_ERR_EN enables MEM_ERR on unmapped or RD+WR requests.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 1,
  parameter logic [(2**SEL_W)-1:0]            REG_PRESENT = 2'b11,
  parameter logic [(2**SEL_W)*WAIT_NIB_W-1:0] WAIT_CYC    = 8'h10
) (
  input  logic                         SYS_CLK,
  input  logic                         SYS_RST,
  input  logic                         MEM_RD,
  input  logic                         MEM_WR,
  input  logic [ADDR_W-1:0]            ADDRESS,
  input  logic [DATA_W-1:0]            WDATA,
  output logic [DATA_W-1:0]            RDATA,
  output logic                         MEM_READY,
  output logic                         MEM_ERR,
  output logic [(2**SEL_W)-1:0]        DEV_EN,
  output logic                         DEV_RD,
  output logic                         DEV_WR,
  output logic [ADDR_W-1:0]            DEV_ADDR,
  output logic [DATA_W-1:0]            DEV_WDATA,
  input  logic [(2**SEL_W)*DATA_W-1:0] DEV_RDATA
);

  localparam int NREG = 2**SEL_W;

`ifdef MEM_BUS_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic [WAIT_NIB_W-1:0] wait_arr [NREG];
  logic [DATA_W-1:0]     rd_arr   [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_region
      assign wait_arr[gi] = WAIT_CYC[gi*WAIT_NIB_W +: WAIT_NIB_W];
      assign rd_arr[gi]   = DEV_RDATA[gi*DATA_W +: DATA_W];
    end
  endgenerate

  state_t           state;
  logic [SEL_W-1:0] req_region;
  logic [SEL_W-1:0] cur_region;
  logic             dir_rd;
  logic             req_one;
  logic             req_both;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  assign req_region = ADDRESS[ADDR_W-1 -: SEL_W];
  assign req_one    = MEM_RD ^ MEM_WR;
  assign req_both   = MEM_RD & MEM_WR;
  assign cnt_load   = (state == ST_IDLE) && req_one;
  assign cnt_dec    = (state == ST_ACCESS) && !cnt_zero;

  mem_bus_waitcnt #(.W(WAIT_NIB_W)) u_waitcnt (
    .clk      (SYS_CLK),
    .rst      (SYS_RST),
    .load     (cnt_load),
    .load_val (wait_arr[req_region]),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state      <= ST_IDLE;
      RDATA      <= '0;
      MEM_READY  <= 1'b0;
      MEM_ERR    <= 1'b0;
      DEV_EN     <= '0;
      DEV_RD     <= 1'b0;
      DEV_WR     <= 1'b0;
      DEV_ADDR   <= '0;
      DEV_WDATA  <= '0;
      cur_region <= '0;
      dir_rd     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          MEM_READY <= 1'b0;
          MEM_ERR   <= 1'b0;
          if (req_both) begin
            // Conflicting request never reaches a device.
            state     <= ST_DONE;
            MEM_READY <= 1'b1;
            MEM_ERR   <= ERR_ON;
          end else if (req_one) begin
            DEV_ADDR   <= ADDRESS;
            DEV_WDATA  <= WDATA;
            cur_region <= req_region;
            dir_rd     <= MEM_RD;
            if (REG_PRESENT[req_region]) begin
              state  <= ST_ACCESS;
              DEV_EN <= NREG'(1) << req_region;
              DEV_RD <= MEM_RD;
              DEV_WR <= MEM_WR;
            end else begin
              state     <= ST_DONE;
              MEM_READY <= 1'b1;
              MEM_ERR   <= ERR_ON;
              if (MEM_RD) begin
                RDATA <= {DATA_W{UNMAPPED_BIT}};
              end
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_zero) begin
            if (dir_rd) begin
              RDATA <= rd_arr[cur_region];
            end
            DEV_EN    <= '0;
            DEV_RD    <= 1'b0;
            DEV_WR    <= 1'b0;
            MEM_READY <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          MEM_READY <= 1'b0;
          MEM_ERR   <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: default map plus a ROM-only instance for unmapped reads.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0;
  logic        rd_u = 1'b0, wr_u = 1'b0;
  logic [12:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [15:0] dev_rdata = '0;

  logic [7:0]  rdata, rdata_u;
  logic        ready, ready_u, err, err_u;
  logic [1:0]  dev_en, dev_en_u;
  logic        dev_rd, dev_wr, dev_rd_u, dev_wr_u;
  logic [12:0] dev_addr, dev_addr_u;
  logic [7:0]  dev_wdata, dev_wdata_u;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MEM_BUS_ERR_EN
  logic exp_err = 1'b1;
`else
  logic exp_err = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .SYS_CLK(clk), .SYS_RST(rst), .MEM_RD(rd), .MEM_WR(wr),
    .ADDRESS(addr), .WDATA(wdata), .RDATA(rdata), .MEM_READY(ready),
    .MEM_ERR(err), .DEV_EN(dev_en), .DEV_RD(dev_rd), .DEV_WR(dev_wr),
    .DEV_ADDR(dev_addr), .DEV_WDATA(dev_wdata), .DEV_RDATA(dev_rdata)
  );

  mem_bus_ctrl #(.REG_PRESENT(2'b01)) dut_u (
    .SYS_CLK(clk), .SYS_RST(rst), .MEM_RD(rd_u), .MEM_WR(wr_u),
    .ADDRESS(addr), .WDATA(wdata), .RDATA(rdata_u), .MEM_READY(ready_u),
    .MEM_ERR(err_u), .DEV_EN(dev_en_u), .DEV_RD(dev_rd_u), .DEV_WR(dev_wr_u),
    .DEV_ADDR(dev_addr_u), .DEV_WDATA(dev_wdata_u), .DEV_RDATA(dev_rdata)
  );

  // Issues one request on dut (called #1 after an edge), records what the bus did,
  // drops the request at the edge that ends DONE and returns #1 after it.
  task automatic run_req(input logic r, input logic w, input logic [12:0] a,
                         input logic [7:0] d, output int lat, output int en_cyc,
                         output logic [1:0] en_seen, output int rd_cyc, output int wr_cyc,
                         output logic [7:0] wd_seen, output logic err_seen,
                         output logic [7:0] rd_val, output logic ready_after);
    rd = r; wr = w; addr = a; wdata = d;
    lat = -1; en_cyc = 0; en_seen = '0; rd_cyc = 0; wr_cyc = 0;
    wd_seen = '0; err_seen = 1'b0; rd_val = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dev_en != '0) begin en_cyc++; en_seen |= dev_en; end
      if (dev_rd) rd_cyc++;
      if (dev_wr) begin wr_cyc++; wd_seen = dev_wdata; end
      if (ready) begin lat = i; err_seen = err; rd_val = rdata; break; end
    end
    @(posedge clk); #1;
    ready_after = ready;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ready, err, dev_en, dev_rd, dev_wr} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl got=%b want=000000", {ready, err, dev_en, dev_rd, dev_wr});
    end
    n_cmp++;
    if ({rdata, dev_addr, dev_wdata} !== 29'h0) begin
      n_bad++; $display("FAIL reset_data got=%h want=0", {rdata, dev_addr, dev_wdata});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: released");
  endtask

  task automatic test_zero_wait_read();
    int lat, en_cyc, rd_cyc, wr_cyc;
    logic [1:0] en_seen;
    logic [7:0] wd, rv;
    logic e, ra;
    dev_rdata = 16'h00A5;
    run_req(1'b1, 1'b0, 13'h0010, 8'h00, lat, en_cyc, en_seen, rd_cyc, wr_cyc, wd, e, rv, ra);
    $display("zero_wait_read: addr=0010 lat=%0d en=%b rdata=%h err=%b", lat, en_seen, rv, e);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL zw_latency got=%0d want=2", lat); end
    n_cmp++; if (en_cyc !== 1 || en_seen !== 2'b01) begin
      n_bad++; $display("FAIL zw_dev_en got=%0d/%b want=1/01", en_cyc, en_seen); end
    n_cmp++; if (rd_cyc !== 1 || wr_cyc !== 0) begin
      n_bad++; $display("FAIL zw_strobes got=%0d/%0d want=1/0", rd_cyc, wr_cyc); end
    n_cmp++; if (rv !== 8'hA5) begin n_bad++; $display("FAIL zw_rdata got=%h want=a5", rv); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL zw_err got=%b want=0", e); end
    n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL zw_ready_pulse got=%b want=0", ra); end
  endtask

  task automatic test_waited_write();
    int lat, en_cyc, rd_cyc, wr_cyc;
    logic [1:0] en_seen;
    logic [7:0] wd, rv;
    logic e, ra;
    run_req(1'b0, 1'b1, 13'h1004, 8'h3C, lat, en_cyc, en_seen, rd_cyc, wr_cyc, wd, e, rv, ra);
    $display("waited_write: addr=1004 lat=%0d en=%b wcyc=%0d wdata=%h", lat, en_seen, wr_cyc, wd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ww_latency got=%0d want=3", lat); end
    n_cmp++; if (en_cyc !== 2 || en_seen !== 2'b10) begin
      n_bad++; $display("FAIL ww_dev_en got=%0d/%b want=2/10", en_cyc, en_seen); end
    n_cmp++; if (wr_cyc !== 2 || rd_cyc !== 0) begin
      n_bad++; $display("FAIL ww_strobes got=%0d/%0d want=2/0", wr_cyc, rd_cyc); end
    n_cmp++; if (wd !== 8'h3C) begin n_bad++; $display("FAIL ww_wdata got=%h want=3c", wd); end
    n_cmp++; if (rdata !== 8'hA5) begin n_bad++; $display("FAIL ww_rdata_hold got=%h want=a5", rdata); end
    n_cmp++; if (dev_addr !== 13'h1004 || dev_wdata !== 8'h3C) begin
      n_bad++; $display("FAIL ww_latch_hold got=%h/%h want=1004/3c", dev_addr, dev_wdata); end
  endtask

  task automatic test_unmapped();
    int lat = -1;
    int en_cyc = 0;
    logic e = 1'b0;
    logic [7:0] rv = '0;
    rd_u = 1'b1; addr = 13'h1000;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dev_en_u != '0 || dev_rd_u || dev_wr_u) en_cyc++;
      if (ready_u) begin lat = i; e = err_u; rv = rdata_u; break; end
    end
    @(posedge clk); #1;
    rd_u = 1'b0;
    $display("unmapped_read: addr=1000 lat=%0d rdata=%h err=%b", lat, rv, e);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL um_latency got=%0d want=1", lat); end
    n_cmp++; if (en_cyc !== 0) begin n_bad++; $display("FAIL um_dev_access got=%0d want=0", en_cyc); end
    n_cmp++; if (rv !== 8'hFF) begin n_bad++; $display("FAIL um_rdata got=%h want=ff", rv); end
    n_cmp++; if (e !== exp_err) begin n_bad++; $display("FAIL um_err got=%b want=%b", e, exp_err); end
  endtask

  task automatic test_illegal();
    int lat, en_cyc, rd_cyc, wr_cyc;
    logic [1:0] en_seen;
    logic [7:0] wd, rv;
    logic e, ra;
    run_req(1'b1, 1'b1, 13'h0020, 8'h11, lat, en_cyc, en_seen, rd_cyc, wr_cyc, wd, e, rv, ra);
    $display("illegal_rdwr: lat=%0d en_cyc=%0d err=%b rdata=%h", lat, en_cyc, e, rv);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL il_latency got=%0d want=1", lat); end
    n_cmp++; if (en_cyc !== 0 || rd_cyc !== 0 || wr_cyc !== 0) begin
      n_bad++; $display("FAIL il_dev_access got=%0d/%0d/%0d want=0/0/0", en_cyc, rd_cyc, wr_cyc); end
    n_cmp++; if (e !== exp_err) begin n_bad++; $display("FAIL il_err got=%b want=%b", e, exp_err); end
    n_cmp++; if (rv !== 8'hA5) begin n_bad++; $display("FAIL il_rdata_hold got=%h want=a5", rv); end
  endtask

  task automatic test_back_to_back();
    int lat, en_cyc, rd_cyc, wr_cyc;
    logic [1:0] en_seen;
    logic [7:0] wd, rv;
    logic e, ra;
    dev_rdata = 16'h5AC3;
    run_req(1'b1, 1'b0, 13'h0000, 8'h00, lat, en_cyc, en_seen, rd_cyc, wr_cyc, wd, e, rv, ra);
    $display("b2b_read0: addr=0000 lat=%0d rdata=%h", lat, rv);
    n_cmp++; if (lat !== 2 || rv !== 8'hC3) begin
      n_bad++; $display("FAIL b2b_first got=%0d/%h want=2/c3", lat, rv); end
    run_req(1'b1, 1'b0, 13'h1000, 8'h00, lat, en_cyc, en_seen, rd_cyc, wr_cyc, wd, e, rv, ra);
    $display("b2b_read1: addr=1000 lat=%0d rdata=%h", lat, rv);
    n_cmp++; if (lat !== 3 || rv !== 8'h5A) begin
      n_bad++; $display("FAIL b2b_second got=%0d/%h want=3/5a", lat, rv); end
    n_cmp++; if (en_seen !== 2'b10 || e !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second_en got=%b/%b want=10/0", en_seen, e); end
  endtask

  task automatic test_reset_mid();
    int lat, en_cyc, rd_cyc, wr_cyc;
    logic [1:0] en_seen;
    logic [7:0] wd, rv;
    logic e, ra;
    logic ready_seen = 1'b0;
    rd = 1'b1; addr = 13'h1000;
    @(posedge clk); #1;
    n_cmp++; if (dev_en !== 2'b10) begin n_bad++; $display("FAIL rm_in_access got=%b want=10", dev_en); end
    #2; rst = 1'b1; #1;
    n_cmp++;
    if ({ready, err, dev_en, dev_rd, dev_wr, rdata, dev_addr} !== 27'h0) begin
      n_bad++; $display("FAIL rm_outputs got=%h want=0", {ready, err, dev_en, dev_rd, dev_wr, rdata, dev_addr});
    end
    rd = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (ready) ready_seen = 1'b1; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ready) ready_seen = 1'b1; end
    n_cmp++; if (ready_seen !== 1'b0) begin n_bad++; $display("FAIL rm_no_ready got=1 want=0"); end
    dev_rdata = 16'h0077;
    run_req(1'b1, 1'b0, 13'h0004, 8'h00, lat, en_cyc, en_seen, rd_cyc, wr_cyc, wd, e, rv, ra);
    $display("reset_mid: recovery read lat=%0d rdata=%h", lat, rv);
    n_cmp++; if (lat !== 2 || rv !== 8'h77) begin
      n_bad++; $display("FAIL rm_recovery got=%0d/%h want=2/77", lat, rv); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_waited_write();
    test_unmapped();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
